// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stall requests into a per-stage stall vector and turns exceptions/ertn into a held flush + redirect PC; all outputs registered, 1-cycle latency.
// No backpressure: inputs are consumed or dropped at the edge they are sampled; optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned              STAGES       = 7,
  parameter int unsigned              NREQ         = 2,
  parameter logic [NREQ*STAGES-1:0]   STALL_MASK   = {7'b0111111, 7'b0111111},
  parameter int unsigned              EXC_W        = 2,
  parameter int unsigned              FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq_i,
  input  logic [EXC_W-1:0]  excepttype_i,
  input  logic [31:0]       eentry_i,
  input  logic              ertn_i,
  input  logic [31:0]       era_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc_o,
  output logic [31:0]       perf_flush_cnt_o
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT   = 4'(FLUSH_CYCLES - 1);
  localparam state_t     HOLD_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t            state;
  logic [3:0]        cnt;
  logic [STAGES-1:0] stall_merge;
  logic              exc_take;
  logic              event_take;
  logic [31:0]       target_pc;

  always_comb begin
    stall_merge = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stallreq_i[i]) stall_merge = stall_merge | STALL_MASK[i*STAGES +: STAGES];
    end
  end

  // Exception outranks ertn; the code itself is never decoded.
  assign exc_take   = (excepttype_i != '0);
  assign event_take = exc_take || ertn_i;
  assign target_pc  = exc_take ? eentry_i : era_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      stall_o  <= '0;
      flush_o  <= 1'b0;
      new_pc_o <= '0;
    end else begin
      case (state)
        RUN: begin
          if (event_take) begin
            flush_o  <= 1'b1;
            new_pc_o <= target_pc;
            stall_o  <= '0;
            cnt      <= CNT_INIT;
            state    <= HOLD_STATE;
          end else begin
            flush_o  <= 1'b0;
            new_pc_o <= '0;
            stall_o  <= stall_merge;
          end
        end
        FLUSH: begin
          // flush_o/new_pc_o hold; anything arriving now is dropped.
          stall_o <= '0;
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc_o <= '0;
      perf_flush_cnt_o <= '0;
    end else if (state == RUN) begin
      if (event_take) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      else if (stall_merge != '0) perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic, checked against a cycle-level reference model.
module tb_pipe_ctrl;

  localparam int FC = 3;
  localparam logic [6:0] MASK0 = 7'b0000011;
  localparam logic [6:0] MASK1 = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  stallreq_i = 2'b00;
  logic [1:0]  excepttype_i = 2'b00;
  logic [31:0] eentry_i = '0;
  logic        ertn_i = 1'b0;
  logic [31:0] era_i = '0;
  logic [6:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  pipe_ctrl #(
    .STAGES(7), .NREQ(2), .STALL_MASK({MASK1, MASK0}), .EXC_W(2), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
    .eentry_i(eentry_i), .ertn_i(ertn_i), .era_i(era_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc_o(perf_stall_cyc_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;

  // Reference model: remaining held flush cycles plus the latched target.
  int          m_hold = 0;
  logic        m_flush = 1'b0;
  logic [31:0] m_pc = '0;
  logic [6:0]  m_stall = '0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] req, input logic [1:0] exc,
                      input logic ert, input logic [31:0] ee, input logic [31:0] ea);
    exp_t e;
    @(negedge clk);
    rst = r; stallreq_i = req; excepttype_i = exc; ertn_i = ert; eentry_i = ee; era_i = ea;
    if (r) begin
      m_hold = 0; m_flush = 0; m_pc = 0; m_stall = 0; m_sc = 0; m_fc = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      m_stall = 0;
    end else if (exc != 0 || ert) begin
      m_flush = 1; m_stall = 0; m_hold = FC - 1; m_fc++;
      m_pc = (exc != 0) ? ee : ea;
    end else begin
      m_flush = 0; m_pc = 0;
      m_stall = (req[0] ? MASK0 : 7'b0) | (req[1] ? MASK1 : 7'b0);
      if (m_stall != 0) m_sc++;
    end
    e.stall = m_stall; e.flush = m_flush; e.pc = m_pc; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic idle(input logic [1:0] req);
    step(1'b0, req, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: every cycle is an output beat; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("stall_o", 32'(stall_o), 32'(e.stall));
          check("flush_o", 32'(flush_o), 32'(e.flush));
          check("new_pc_o", new_pc_o, e.pc);
`ifdef PIPE_CTRL_PERF_EN
          check("perf_stall_cyc_o", perf_stall_cyc_o, e.sc);
          check("perf_flush_cnt_o", perf_flush_cnt_o, e.fc);
`endif
        end
      end
    end
  end

  initial begin
    logic [1:0] exc;
    // Reset held with live requests and an exception pending.
    step(1'b1, 2'b11, 2'b01, 1'b0, 32'hDEAD_0000, 32'h0);
    step(1'b1, 2'b11, 2'b01, 1'b0, 32'hDEAD_0000, 32'h0);
    // Stall merge and one-cycle release.
    idle(2'b01);
    idle(2'b11);
    idle(2'b10);
    idle(2'b00);
    idle(2'b00);
    // Exception beats ertn and stalls.
    step(1'b0, 2'b11, 2'b10, 1'b1, 32'h1C00_0100, 32'h1C00_2000);
    idle(2'b11);
    idle(2'b11);
    idle(2'b00);
    // ertn flush hold, with an exception dropped during the hold.
    step(1'b0, 2'b00, 2'b00, 1'b1, 32'h0, 32'h0000_0040);
    step(1'b0, 2'b01, 2'b01, 1'b0, 32'h8000_0000, 32'h0);
    step(1'b0, 2'b11, 2'b11, 1'b1, 32'h8000_0004, 32'h9);
    idle(2'b01);
    idle(2'b00);
    // Reset in the middle of a flush hold.
    step(1'b0, 2'b00, 2'b01, 1'b0, 32'h1234_5678, 32'h0);
    step(1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    idle(2'b10);
    // Event immediately after a hold ends.
    step(1'b0, 2'b00, 2'b00, 1'b1, 32'h0, 32'hAAAA_0000);
    idle(2'b00);
    idle(2'b00);
    step(1'b0, 2'b00, 2'b11, 1'b0, 32'hBBBB_0000, 32'h0);
    idle(2'b00);
    idle(2'b00);
    idle(2'b00);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      exc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), exc,
           ($urandom_range(0, 7) == 0), $urandom, $urandom);
    end
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
